// File: rtl/bit_reversal_pkg.sv
// Shared constants for the bit-reversal board: ASCII characters used on the UART
// and the state encoding of the binary ASCII printer.
package bit_reversal_pkg;

    localparam logic [7:0] CHAR_0  = 8'h30;
    localparam logic [7:0] CHAR_1  = 8'h31;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_HOLD,
        ST_SEND_CR,
        ST_HOLD_CR,
        ST_SEND_LF,
        ST_HOLD_LF
    } printer_state_t;

endpackage

// File: rtl/binary_ascii_printer.sv
// Prints one word as ASCII '0'/'1' (+ optional CR LF); one char per >= 2 cycles, 2*W(+4) cycles with TX idle.
// Backpressure: value_ready only in IDLE (no buffering); tx_busy stalls in SEND* states indefinitely.
module binary_ascii_printer
    import bit_reversal_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int MSB_FIRST   = 1,
    parameter int APPEND_CRLF = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] value_in,
    input  logic                  value_valid,
    output logic                  value_ready,
    output logic [7:0]            tx_data,
    output logic                  new_tx_data,
    input  logic                  tx_busy,
    output logic                  done
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    printer_state_t        state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         cnt;
    logic                  cur_bit;
    logic [DATA_WIDTH-1:0] shreg_next;

    assign cur_bit     = (MSB_FIRST != 0) ? shreg[DATA_WIDTH-1] : shreg[0];
    assign shreg_next  = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
    assign value_ready = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            cnt         <= '0;
            tx_data     <= 8'h00;
            new_tx_data <= 1'b0;
            done        <= 1'b0;
        end else begin
            new_tx_data <= 1'b0;
            done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (value_valid) begin
                        shreg <= value_in;
                        cnt   <= CW'(DATA_WIDTH);
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_data     <= cur_bit ? CHAR_1 : CHAR_0;
                        new_tx_data <= 1'b1;
                        cnt         <= cnt - CW'(1);
                        shreg       <= shreg_next;
                        state       <= ST_HOLD;
                    end
                end
                // The TX busy flag lags the strobe by a cycle, so HOLD never looks at it.
                ST_HOLD: begin
                    if (cnt != '0) begin
                        state <= ST_SEND;
                    end else if (APPEND_CRLF != 0) begin
                        state <= ST_SEND_CR;
                    end else begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                ST_SEND_CR: begin
                    if (!tx_busy) begin
                        tx_data     <= CHAR_CR;
                        new_tx_data <= 1'b1;
                        state       <= ST_HOLD_CR;
                    end
                end
                ST_HOLD_CR: state <= ST_SEND_LF;
                ST_SEND_LF: begin
                    if (!tx_busy) begin
                        tx_data     <= CHAR_LF;
                        new_tx_data <= 1'b1;
                        state       <= ST_HOLD_LF;
                    end
                end
                ST_HOLD_LF: begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_ascii_printer.sv
// Bench for binary_ascii_printer: three configurations (defaults, LSB-first without
// terminator, single-bit word) checked against a character scoreboard.
module tb_binary_ascii_printer;

    localparam int BUDGET = 2000;
    localparam int CFG_W [3] = '{8, 8, 1};
    localparam int CFG_M [3] = '{1, 0, 1};
    localparam int CFG_C [3] = '{1, 0, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] vin  [3];
    logic        vvld [3];
    logic        vrdy [3];
    logic [7:0]  txd  [3];
    logic        stb  [3];
    logic        busy [3];
    logic        dn   [3];

    logic [7:0]  exp_q [3][$];
    int          len_q [3][$];
    int          chars_since [3];
    int          done_cnt [3];
    int          exp_done [3];
    int          done_cyc [3];
    int          acc_cyc  [3];
    logic        prev_stb [3];
    logic        busy_snap [3];
    logic        busy_en;
    int          bcnt;
    int          cyc;
    int          checks;
    int          errors;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    binary_ascii_printer u_dut (
        .clk(clk), .rst_n(rst_n), .value_in(vin[0][7:0]), .value_valid(vvld[0]),
        .value_ready(vrdy[0]), .tx_data(txd[0]), .new_tx_data(stb[0]),
        .tx_busy(busy[0]), .done(dn[0])
    );

    binary_ascii_printer #(.DATA_WIDTH(8), .MSB_FIRST(0), .APPEND_CRLF(0)) u_dut_lsb (
        .clk(clk), .rst_n(rst_n), .value_in(vin[1][7:0]), .value_valid(vvld[1]),
        .value_ready(vrdy[1]), .tx_data(txd[1]), .new_tx_data(stb[1]),
        .tx_busy(busy[1]), .done(dn[1])
    );

    binary_ascii_printer #(.DATA_WIDTH(1), .MSB_FIRST(1), .APPEND_CRLF(1)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n), .value_in(vin[2][0:0]), .value_valid(vvld[2]),
        .value_ready(vrdy[2]), .tx_data(txd[2]), .new_tx_data(stb[2]),
        .tx_busy(busy[2]), .done(dn[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // Busy model: once enabled, TX stays busy for 10 cycles after each strobe on DUT 0.
    initial begin
        busy[0] = 1'b0;
        bcnt    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (busy_en && stb[0]) bcnt = 10;
            busy[0] = (bcnt > 0);
            if (bcnt > 0) bcnt--;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_mon
        always @(posedge clk) busy_snap[g] <= busy[g];

        always @(negedge clk) begin
            if (stb[g] === 1'b1) begin
                check("strobe_gap", 32'(prev_stb[g]), 0);
                check("busy_at_strobe", 32'(busy_snap[g]), 0);
                check("strobe_expected", 32'(exp_q[g].size() != 0), 1);
                if (exp_q[g].size() != 0) check("tx_char", 32'(txd[g]), 32'(exp_q[g].pop_front()));
                chars_since[g]++;
            end
            if (dn[g] === 1'b1) begin
                done_cnt[g]++;
                done_cyc[g] = cyc;
                check("done_expected", 32'(len_q[g].size() != 0), 1);
                if (len_q[g].size() != 0) check("done_len", 32'(chars_since[g]), 32'(len_q[g].pop_front()));
                chars_since[g] = 0;
            end
            prev_stb[g] = stb[g];
        end
    end

    task automatic push_word(input int d, input logic [15:0] v);
        int n;
        int b;
        n = 0;
        for (int i = 0; i < CFG_W[d]; i++) begin
            b = (CFG_M[d] != 0) ? (CFG_W[d] - 1 - i) : i;
            exp_q[d].push_back(v[b] ? 8'h31 : 8'h30);
            n++;
        end
        if (CFG_C[d] != 0) begin
            exp_q[d].push_back(8'h0D);
            exp_q[d].push_back(8'h0A);
            n += 2;
        end
        len_q[d].push_back(n);
        exp_done[d]++;
    endtask

    task automatic print_word(input int d, input logic [15:0] v);
        int n;
        push_word(d, v);
        @(negedge clk);
        vin[d]  = v;
        vvld[d] = 1'b1;
        n = 0;
        while (!vrdy[d] && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(vrdy[d]), 1);
        @(posedge clk);
        #1;
        acc_cyc[d] = cyc;
        vvld[d]    = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        while (done_cnt[d] < exp_done[d] && n < BUDGET) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_timeout", 32'(done_cnt[d] >= exp_done[d]), 1);
    endtask

    initial begin
        int n;
        int cd;
        rst_n   = 1'b0;
        busy_en = 1'b0;
        busy[1] = 1'b0;
        busy[2] = 1'b0;
        cyc     = 0;
        checks  = 0;
        errors  = 0;
        for (int d = 0; d < 3; d++) begin
            vin[d] = '0; vvld[d] = 1'b0; chars_since[d] = 0; done_cnt[d] = 0;
            exp_done[d] = 0; prev_stb[d] = 1'b0; done_cyc[d] = 0; acc_cyc[d] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_tx_data", 32'(txd[0]), 0);
        check("rst_strobe", 32'(stb[0]), 0);
        check("rst_done", 32'(dn[0]), 0);
        check("rst_ready", 32'(vrdy[0]), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // MSB-first with CRLF, TX idle: fixed 20-cycle print
        print_word(0, 16'h00A5);
        wait_done(0);
        check("latency_a5", 32'(done_cyc[0] - acc_cyc[0]), 20);
        check("ready_after_a5", 32'(vrdy[0]), 1);

        // LSB-first, no terminator
        print_word(1, 16'h0001);
        wait_done(1);

        // TX busy for 10 cycles after every strobe
        busy_en = 1'b1;
        print_word(0, 16'h003C);
        wait_done(0);
        busy_en = 1'b0;
        repeat (12) @(negedge clk);

        // valid held through a print; new word must wait for the current one
        push_word(0, 16'h0000);
        push_word(0, 16'h00FF);
        @(negedge clk);
        vin[0] = 16'h0000; vvld[0] = 1'b1;
        @(posedge clk);
        #1;
        repeat (5) @(negedge clk);
        vin[0] = 16'h00FF;
        n = 0;
        while (!dn[0] && n < BUDGET) begin
            check("ready_low_mid_print", 32'(vrdy[0]), 0);
            @(negedge clk);
            n++;
        end
        check("done_seen_00", 32'(dn[0]), 1);
        check("ready_at_done", 32'(vrdy[0]), 1);
        cd = cyc;
        @(posedge clk);
        #1;
        check("accept_after_done", 32'(cyc - cd), 1);
        vvld[0] = 1'b0;
        wait_done(0);

        // asynchronous reset after the 3rd strobe of 0xA5
        exp_q[0].push_back(8'h31);
        exp_q[0].push_back(8'h30);
        exp_q[0].push_back(8'h31);
        @(negedge clk);
        vin[0] = 16'h00A5; vvld[0] = 1'b1;
        @(posedge clk);
        #1;
        vvld[0] = 1'b0;
        n = 0;
        while (chars_since[0] < 3 && n < BUDGET) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("third_strobe_seen", 32'(chars_since[0]), 3);
        rst_n = 1'b0;
        #1;
        check("async_rst_strobe", 32'(stb[0]), 0);
        check("async_rst_tx_data", 32'(txd[0]), 0);
        check("async_rst_ready", 32'(vrdy[0]), 1);
        chars_since[0] = 0;
        #1;
        rst_n = 1'b1;
        print_word(0, 16'h005A);
        wait_done(0);

        // single-bit word
        print_word(2, 16'h0001);
        wait_done(2);
        check("w1_ready", 32'(vrdy[2]), 1);

        repeat (5) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("chars_left", 32'(exp_q[d].size()), 0);
            check("done_count", 32'(done_cnt[d]), 32'(exp_done[d]));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/binary_ascii_printer.md
Name: binary_ascii_printer

Overview:
Transmit-side counterpart of the ASCII bit collector. It accepts one parallel word and prints it to the UART transmitter as a string of ASCII '0'/'1' characters, optionally followed by CR LF. It sits between the bit-reversal datapath output and the avr_interface serial TX port (tx_data/new_tx_data/tx_busy). It gives the board a way to echo computed results back to the host terminal.

Parameters:
DATA_WIDTH, 8, width of the word to print; legal range 1..16.
MSB_FIRST, 1, 1 = print bit DATA_WIDTH-1 first; 0 = print bit 0 first.
APPEND_CRLF, 1, 1 = send 0x0D then 0x0A after the last bit character; 0 = no terminator.

Ports:
clk  in  1  system clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
value_in  in  DATA_WIDTH  word to print; sampled only on the accept cycle.
value_valid  in  1  producer has a word to print.
value_ready  out  1  high only in IDLE; a word is accepted on a rising edge where value_valid && value_ready.
tx_data  out  8  character to UART TX; registered.
new_tx_data  out  1  one-cycle strobe, registered; tx_data is valid in the same cycle.
tx_busy  in  1  UART TX is busy; no strobe may be issued while it is high.
done  out  1  one-cycle pulse, registered, after the final character's strobe cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, tx_data=8'h00, new_tx_data=0, done=0, shift register=0, bit counter=0.
  - Any print in progress is abandoned with no partial terminator.
  - value_ready goes high combinationally from IDLE.
- States: IDLE, SEND, HOLD, SEND_CR, HOLD_CR, SEND_LF, HOLD_LF.
- IDLE:
  - value_ready=1.
  - On accept: latch value_in into the shift register, load bit counter=DATA_WIDTH, go to SEND.
  - value_valid without an accept (not IDLE) is ignored. There is no buffering; the producer must hold its word.
- SEND:
  - If tx_busy=0: on the next edge, tx_data <= (current bit ? 8'h31 : 8'h30), new_tx_data <= 1, decrement the counter, shift toward the next bit (per MSB_FIRST), go to HOLD.
  - If tx_busy=1: stay in SEND with new_tx_data=0.
- HOLD:
  - Holdoff of exactly one cycle; tx_busy is ignored. This covers the one-cycle lag of the TX busy flag.
  - new_tx_data <= 0.
  - Next state: SEND if counter != 0; else SEND_CR if APPEND_CRLF; else IDLE with done pulsed.
- SEND_CR/HOLD_CR and SEND_LF/HOLD_LF: same rules as SEND/HOLD, with characters 8'h0D and 8'h0A.
  - HOLD_LF goes to IDLE and pulses done.
- Timing:
  - Each character takes at least 2 cycles: strobe cycle plus holdoff.
  - The first strobe comes no earlier than 1 cycle after accept.
  - With tx_busy tied low, one word takes 2*DATA_WIDTH (+4 if CRLF) cycles from accept to return to IDLE.
  - value_ready re-asserts in the cycle after the done pulse edge, so back-to-back words lose no extra cycles.
- tx_data holds its last value between strobes and is only meaningful while new_tx_data=1.
- A tx_busy stuck high stalls indefinitely in SEND*; there is no timeout.
- Bit counter width is $clog2(DATA_WIDTH+1); it never wraps, because it is reloaded only in IDLE.
- DATA_WIDTH=1: exactly one bit character, then the terminator.

Decomposition:
- Shared package (bit_reversal_pkg): ASCII constants CHAR_0=8'h30, CHAR_1=8'h31, CHAR_CR=8'h0D, CHAR_LF=8'h0A, and the state encoding for this block.
- No sub-module. The shift register, counter and FSM are one small always_ff/always_comb pair; splitting them adds nothing.

Test Plan:
1. tx_busy tied low, defaults, accept 8'hA5 → strobes carry 31 30 31 30 30 31 30 31 0D 0A; every strobe is followed by a zero cycle; done once; 20 cycles accept-to-IDLE.
2. MSB_FIRST=0, APPEND_CRLF=0, accept 8'h01 → strobes 31 30 30 30 30 30 30 30; done after the 8th strobe; no 0D/0A.
3. Bench TX model raises tx_busy for 10 cycles after each strobe → exactly 10 strobes for 8'h3C with characters 30 30 31 31 31 31 30 30 0D 0A; no strobe while tx_busy=1.
4. value_valid held high with value_in changed to 8'hFF mid-print of 8'h00 → output is eight 30s plus CRLF; value_ready=0 throughout; 8'hFF accepted in the cycle after done, followed by eight 31s.
5. rst_n pulsed low asynchronously (between edges) after the 3rd strobe → new_tx_data=0 and tx_data=00 immediately; value_ready=1 after release; the next word prints fully with no stray characters.
6. DATA_WIDTH=1, accept 1'b1 → strobes 31 0D 0A; done; IDLE.
